tagged_queue: RTL
=================

TAGGED_QUEUE -- requirements
Module: tagged_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning number of entries (power of two, 2..16).
REQ-002 The module SHALL have parameter DATA_W, default 8, meaning payload width.
REQ-003 The module SHALL have parameter TAG_W, default 2, meaning source-tag width (upstream arbiter chosen index).
REQ-004 The module SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-005 The module SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-006 The module SHALL have port io_enq_valid  input  1  upstream entry offered.
REQ-007 The module SHALL have port io_enq_ready  output  1  queue can accept.
REQ-008 The module SHALL have port io_enq_bits  input  DATA_W  payload.
REQ-009 The module SHALL have port io_enq_chosen  input  TAG_W  source tag stored with the payload.
REQ-010 The module SHALL have port io_deq_valid  output  1  head entry available.
REQ-011 The module SHALL have port io_deq_ready  input  1  downstream accepts.
REQ-012 The module SHALL have port io_deq_bits  output  DATA_W  head payload.
REQ-013 The module SHALL have port io_deq_chosen  output  TAG_W  head tag.
REQ-014 The module SHALL have port io_count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-015 Enqueue fire SHALL be io_enq_valid & io_enq_ready; dequeue fire SHALL be io_deq_valid & io_deq_ready.
REQ-016 Storage SHALL be a circular buffer with head/tail pointers wrapping DEPTH-1 -> 0, plus a maybe_full flag disambiguating pointer equality.
REQ-017 io_enq_ready SHALL be 1 iff not full; io_deq_valid SHALL be 1 iff not empty (flow case per REQ-026).
REQ-018 {bits, chosen} SHALL be written together at tail on enqueue fire; tail advances by one.
REQ-019 io_deq_bits/io_deq_chosen SHALL reflect the head entry combinationally; head advances by one on dequeue fire.
REQ-020 Enqueue-to-dequeue latency SHALL be one cycle: an entry written at edge N is visible on io_deq_* after edge N.
REQ-021 Simultaneous enqueue and dequeue fire SHALL leave io_count unchanged and preserve FIFO order.
REQ-022 When full, io_enq_ready SHALL be 0 even if io_deq_ready is 1 (no pass-through on full).
REQ-023 io_count SHALL increment on enqueue-only, decrement on dequeue-only, never exceed DEPTH or underflow.
REQ-024 io_deq_bits/io_deq_chosen SHALL be don't-care while io_deq_valid is 0.

Reset
REQ-025 Reset assertion SHALL immediately, mid-operation included, clear head, tail, maybe_full, giving io_count=0, io_deq_valid=0, io_enq_ready=1; storage contents are not reset; enqueues in the reset cycle are discarded.

Configuration
REQ-026 With TAGGED_QUEUE_FLOW_EN defined, when empty and io_enq_valid=1, io_deq_valid SHALL be 1 and io_deq_bits/io_deq_chosen SHALL equal io_enq_bits/io_enq_chosen in the same cycle; if io_deq_ready=1 the entry SHALL bypass storage (no pointer or count change).
REQ-027 Without TAGGED_QUEUE_FLOW_EN, an empty queue SHALL hold io_deq_valid=0 that cycle regardless of io_enq_valid.

Structure
REQ-028 A shared package tagged_queue_pkg SHALL hold default DATA_W, TAG_W, DEPTH constants and the entry typedef {tag, data}.
REQ-029 Storage SHALL be a sub-module tagged_queue_ram (1 write port, 1 async read port, DEPTH x (DATA_W+TAG_W)); pointer/count control stays in tagged_queue.

Verification
REQ-030 Bench: reset, enq {0xA5,tag 2} one cycle, deq_ready=1 -> next cycle deq_valid=1, bits=0xA5, chosen=2, count=1; following cycle count=0, deq_valid=0.
REQ-031 Bench: enqueue 4 entries 0x10..0x13 with tags 0..3, deq_ready=0 -> count=4, enq_ready=0; 5th enqueue (0x14) not accepted; drain yields 0x10..0x13 with tags 0..3 in order.
REQ-032 Bench: full queue, enq_valid=1, deq_ready=1 -> only dequeue fires; count 4->3; next cycle enq accepted, count stays 3.
REQ-033 Bench: steady enq+deq every cycle for 20 items (pointer wrap x5) -> output sequence equals input, count constant at 1.
REQ-034 Bench: async reset pulsed mid-cycle with count=3 -> count=0, deq_valid=0, enq_ready=1 before next clock edge.
REQ-035 Bench (FLOW_EN): empty, enq {0x3C,tag 1}, deq_ready=1 -> same cycle deq_valid=1, bits=0x3C, chosen=1; count stays 0.

Source files
------------

// File: rtl/tagged_queue_pkg.sv
// tagged_queue_pkg: default sizes and the {tag, data} entry layout shared by the tagged_queue slice.
package tagged_queue_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int TAG_W_DEF = 2;
  typedef struct packed {
    logic [TAG_W_DEF-1:0] tag;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;
endpackage

// File: rtl/tagged_queue_if.sv
// tagged_queue_if: enqueue/dequeue handshake bundle; master is the producer/consumer side, slave the queue.
interface tagged_queue_if import tagged_queue_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W = TAG_W_DEF
);
  logic io_enq_valid;
  logic io_enq_ready;
  logic [DATA_W-1:0] io_enq_bits;
  logic [TAG_W-1:0] io_enq_chosen;
  logic io_deq_valid;
  logic io_deq_ready;
  logic [DATA_W-1:0] io_deq_bits;
  logic [TAG_W-1:0] io_deq_chosen;
  logic [$clog2(DEPTH):0] io_count;
  modport master (
    output io_enq_valid, io_enq_bits, io_enq_chosen, io_deq_ready,
    input io_enq_ready, io_deq_valid, io_deq_bits, io_deq_chosen, io_count
  );
  modport slave (
    input io_enq_valid, io_enq_bits, io_enq_chosen, io_deq_ready,
    output io_enq_ready, io_deq_valid, io_deq_bits, io_deq_chosen, io_count
  );
endinterface

// File: rtl/tagged_queue_ram.sv
// tagged_queue_ram: DEPTH x W storage, one synchronous write port and one asynchronous read port; not reset.
module tagged_queue_ram import tagged_queue_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W = DATA_W_DEF + TAG_W_DEF
) (
  input  logic clk,
  input  logic we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/tagged_queue.sv
// tagged_queue: circular FIFO storing {chosen, bits} per entry with occupancy count.
// Define TAGGED_QUEUE_FLOW_EN to let an empty queue pass an offered entry straight through.
module tagged_queue import tagged_queue_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input logic clk,
  input logic reset,
  tagged_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W = DATA_W + TAG_W;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic maybe_full_q, maybe_full_d;
  logic empty, full, do_enq, do_deq;
  logic [W-1:0] rd;
  tagged_queue_ram #(.DEPTH(DEPTH), .W(W)) u_ram (
    .clk(clk),
    .we(do_enq),
    .waddr(tail_q),
    .wdata({q.io_enq_chosen, q.io_enq_bits}),
    .raddr(head_q),
    .rdata(rd)
  );
  always_comb begin
    empty = head_q == tail_q && !maybe_full_q;
    full = head_q == tail_q && maybe_full_q;
    q.io_enq_ready = !full;
`ifdef TAGGED_QUEUE_FLOW_EN
    q.io_deq_valid = !empty || q.io_enq_valid;
    {q.io_deq_chosen, q.io_deq_bits} = empty ? {q.io_enq_chosen, q.io_enq_bits} : rd;
    do_enq = q.io_enq_valid && !full && !(empty && q.io_deq_ready);
`else
    q.io_deq_valid = !empty;
    {q.io_deq_chosen, q.io_deq_bits} = rd;
    do_enq = q.io_enq_valid && !full;
`endif
    do_deq = !empty && q.io_deq_ready;
    head_d = do_deq ? head_q + AW'(1) : head_q;
    tail_d = do_enq ? tail_q + AW'(1) : tail_q;
    maybe_full_d = do_enq != do_deq ? do_enq : maybe_full_q;
    q.io_count = full ? CW'(DEPTH) : {1'b0, tail_q - head_q};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      maybe_full_q <= maybe_full_d;
    end
endmodule
